// File: rtl/score_cell_engine.sv
// Score engine for one Needleman-Wunsch cell: requests the diag/up/left neighbours,
// captures them as they return, scores the cell and issues a single write.
//
//  state   | meaning
//  S_IDLE  | waiting for start; i, j and match are latched when start is seen
//  S_REQ   | three read requests, count = 0 (diag), 1 (up), 2 (left)
//  S_WAIT  | requests issued, waiting for the left score to return
//  S_CALC  | candidates formed and best score/direction registered
//  S_WRITE | we/done strobe with wr_addr, wr_data and dir valid
module score_cell_engine #(
    parameter int N           = 128,
    parameter int BitAddr     = $clog2(N + 1),
    parameter int addr_lenght = $clog2((N + 1) * (N + 1)),
    parameter int SW          = 16,
    parameter int MATCH       = 1,
    parameter int MISMATCH    = -1,
    parameter int GAP         = -2,
    parameter int RD_LAT      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BitAddr:0]       i,
    input  logic [BitAddr:0]       j,
    input  logic                   match,
    input  logic [SW-1:0]          data_in,
    output logic                   en_read,
    output logic [1:0]             count,
    output logic [addr_lenght-1:0] wr_addr,
    output logic [SW-1:0]          wr_data,
    output logic [1:0]             dir,
    output logic                   we,
    output logic                   done,
    output logic                   busy
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CALC, S_WRITE} state_t;

    localparam logic signed [SW:0] SUB_MATCH    = MATCH[SW:0];
    localparam logic signed [SW:0] SUB_MISMATCH = MISMATCH[SW:0];
    localparam logic signed [SW:0] GAP_EXT      = GAP[SW:0];

    state_t                   state_q, state_d;
    logic [BitAddr:0]         i_q, i_d, j_q, j_d;
    logic                     match_q, match_d;
    logic [SW-1:0]            diag_q, diag_d, up_q, up_d, left_q, left_d;
    logic [RD_LAT-1:0]        pv_q, pv_d;
    logic [RD_LAT-1:0][1:0]   pt_q, pt_d;
    logic                     en_read_q, en_read_d;
    logic [1:0]               count_q, count_d;
    logic [addr_lenght-1:0]   wr_addr_q, wr_addr_d;
    logic [SW-1:0]            wr_data_q, wr_data_d;
    logic [1:0]               dir_q, dir_d;
    logic                     we_q, we_d, done_q, done_d, busy_q, busy_d;

    logic                     left_cap;
    logic signed [SW:0]       sub, sum_d, sum_u, sum_l;
    logic signed [SW-1:0]     cand_d, cand_u, cand_l, best;
    logic [1:0]               best_dir;
    logic [addr_lenght-1:0]   cell_addr;

    // Clamp an SW+1 bit sum back into the SW-bit signed range.
    function automatic logic [SW-1:0] sat_sw(input logic [SW:0] x);
        if (x[SW] != x[SW-1])
            sat_sw = x[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        else
            sat_sw = x[SW-1:0];
    endfunction

    assign left_cap = pv_q[RD_LAT-1] && (pt_q[RD_LAT-1] == 2'd2);

    always_comb begin
        sub    = match_q ? SUB_MATCH : SUB_MISMATCH;
        sum_d  = $signed({diag_q[SW-1], diag_q}) + sub;
        sum_u  = $signed({up_q[SW-1], up_q}) + GAP_EXT;
        sum_l  = $signed({left_q[SW-1], left_q}) + GAP_EXT;
        cand_d = sat_sw(sum_d);
        cand_u = sat_sw(sum_u);
        cand_l = sat_sw(sum_l);
        if (cand_d >= cand_u && cand_d >= cand_l) begin
            best     = cand_d;
            best_dir = 2'b01;
        end else if (cand_u >= cand_l) begin
            best     = cand_u;
            best_dir = 2'b10;
        end else begin
            best     = cand_l;
            best_dir = 2'b11;
        end
        cell_addr = addr_lenght'(j_q) + addr_lenght'(1)
                  + addr_lenght'(N + 1) * (addr_lenght'(i_q) + addr_lenght'(1));
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        match_d   = match_q;
        diag_d    = diag_q;
        up_d      = up_q;
        left_d    = left_q;
        en_read_d = en_read_q;
        count_d   = count_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        dir_d     = dir_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;

        // Read-return tracker: runs independently of the FSM so any RD_LAT works.
        pv_d    = pv_q;
        pt_d    = pt_q;
        pv_d[0] = en_read_q;
        pt_d[0] = count_q;
        for (int k = 1; k < RD_LAT; k++) begin
            pv_d[k] = pv_q[k-1];
            pt_d[k] = pt_q[k-1];
        end

        if (pv_q[RD_LAT-1]) begin
            case (pt_q[RD_LAT-1])
                2'd0:    diag_d = data_in;
                2'd1:    up_d   = data_in;
                2'd2:    left_d = data_in;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_REQ;
                    i_d       = i;
                    j_d       = j;
                    match_d   = match;
                    en_read_d = 1'b1;
                    count_d   = 2'd0;
                    busy_d    = 1'b1;
                end
            end
            S_REQ: begin
                if (count_q == 2'd2) begin
                    state_d   = S_WAIT;
                    en_read_d = 1'b0;
                end else begin
                    count_d = count_q + 2'd1;
                end
            end
            S_WAIT: begin
                if (left_cap) state_d = S_CALC;
            end
            S_CALC: begin
                state_d   = S_WRITE;
                wr_addr_d = cell_addr;
                wr_data_d = best;
                dir_d     = best_dir;
                we_d      = 1'b1;
                done_d    = 1'b1;
            end
            S_WRITE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                en_read_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            match_q   <= 1'b0;
            diag_q    <= '0;
            up_q      <= '0;
            left_q    <= '0;
            pv_q      <= '0;
            pt_q      <= '0;
            en_read_q <= 1'b0;
            count_q   <= 2'd0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            dir_q     <= 2'b00;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            match_q   <= match_d;
            diag_q    <= diag_d;
            up_q      <= up_d;
            left_q    <= left_d;
            pv_q      <= pv_d;
            pt_q      <= pt_d;
            en_read_q <= en_read_d;
            count_q   <= count_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            dir_q     <= dir_d;
            we_q      <= we_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign en_read = en_read_q;
    assign count   = count_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign dir     = dir_q;
    assign we      = we_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_score_cell_engine.sv
// Bench: four engines (RD_LAT 2/1/3 at SW=16, RD_LAT 2 at SW=8) share one stimulus stream;
// each has its own address-register + RAM latency model and is scored against an arithmetic model.
module tb_score_cell_engine;

    localparam int N = 128;
    localparam int LATS[4] = '{2, 1, 3, 2};
    localparam int SWS[4]  = '{16, 16, 16, 8};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic match = 1'b0;
    logic [8:0] i_in = '0;
    logic [8:0] j_in = '0;

    logic        en_read[4];
    logic [1:0]  count[4];
    logic [14:0] wr_addr[4];
    logic [1:0]  dir[4];
    logic        we[4], done[4], busy[4];
    logic [15:0] wd16[3], di16[3];
    logic [7:0]  wd8, di8;

    logic [15:0] nv[3];
    logic        hv[4][4] = '{default: 1'b0};
    logic [1:0]  ht[4][4] = '{default: 2'd0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int en_cnt[4], we_cnt[4], we_cyc[4], got_data[4], got_addr[4], got_dir[4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_sw16
        score_cell_engine #(.N(N), .SW(16), .RD_LAT(LATS[g])) u_dut (
            .clk(clk), .rst(rst), .start(start), .i(i_in), .j(j_in), .match(match),
            .data_in(di16[g]), .en_read(en_read[g]), .count(count[g]), .wr_addr(wr_addr[g]),
            .wr_data(wd16[g]), .dir(dir[g]), .we(we[g]), .done(done[g]), .busy(busy[g])
        );
    end

    score_cell_engine #(.N(N), .SW(8), .RD_LAT(LATS[3])) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .i(i_in), .j(j_in), .match(match),
        .data_in(di8), .en_read(en_read[3]), .count(count[3]), .wr_addr(wr_addr[3]),
        .wr_data(wd8), .dir(dir[3]), .we(we[3]), .done(done[3]), .busy(busy[3])
    );

    // Address register + synchronous RAM: a request's data appears RD_LAT cycles later.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            hv[k][0] <= en_read[k];
            ht[k][0] <= count[k];
            for (int s = 1; s < 4; s++) begin
                hv[k][s] <= hv[k][s-1];
                ht[k][s] <= ht[k][s-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++)
            di16[k] = hv[k][LATS[k]-1] ? nv[ht[k][LATS[k]-1]] : 16'hA5C3;
        di8 = hv[3][LATS[3]-1] ? nv[ht[3][LATS[3]-1]][7:0] : 8'hC3;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v, input int sw);
        int r;
        r = v & ((1 << sw) - 1);
        if (r >= (1 << (sw - 1))) r = r - (1 << sw);
        return r;
    endfunction

    function automatic int clampv(input int v, input int sw);
        if (v > (1 << (sw - 1)) - 1) return (1 << (sw - 1)) - 1;
        if (v < -(1 << (sw - 1))) return -(1 << (sw - 1));
        return v;
    endfunction

    task automatic model(input int sw, input int d, input int u, input int l, input bit m,
                         output int res, output int dr);
        int cd, cu, cl;
        cd = clampv(sx(d, sw) + (m ? 1 : -1), sw);
        cu = clampv(sx(u, sw) - 2, sw);
        cl = clampv(sx(l, sw) - 2, sw);
        if (cd >= cu && cd >= cl) begin res = cd; dr = 1; end
        else if (cu >= cl)        begin res = cu; dr = 2; end
        else                      begin res = cl; dr = 3; end
    endtask

    function automatic bit all_idle();
        return !(busy[0] | busy[1] | busy[2] | busy[3]);
    endfunction

    function automatic bit all_written();
        return (we_cnt[0] > 0) && (we_cnt[1] > 0) && (we_cnt[2] > 0) && (we_cnt[3] > 0);
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (en_read[k]) begin
                    chk($sformatf("seq%0d", k), int'(count[k]), en_cnt[k]);
                    en_cnt[k]++;
                end
                if (we[k] || done[k]) chk($sformatf("done_we%0d", k), int'(done[k]), int'(we[k]));
                if (we[k]) begin
                    we_cnt[k]++;
                    we_cyc[k]   = cyc - start_cyc;
                    got_addr[k] = int'(wr_addr[k]);
                    got_dir[k]  = int'(dir[k]);
                    if (k < 3) got_data[k] = int'($signed(wd16[k]));
                    else       got_data[k] = int'($signed(wd8));
                end
            end
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 4; k++) begin
            en_cnt[k] = 0;
            we_cnt[k] = 0;
            we_cyc[k] = -1;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_en%0d", tag, k), int'(en_read[k]), 0);
            chk($sformatf("%s_cnt%0d", tag, k), int'(count[k]), 0);
            chk($sformatf("%s_we%0d", tag, k), int'(we[k]), 0);
            chk($sformatf("%s_done%0d", tag, k), int'(done[k]), 0);
            chk($sformatf("%s_busy%0d", tag, k), int'(busy[k]), 0);
            chk($sformatf("%s_addr%0d", tag, k), int'(wr_addr[k]), 0);
            chk($sformatf("%s_dir%0d", tag, k), int'(dir[k]), 0);
            chk($sformatf("%s_data%0d", tag, k), (k < 3) ? int'(wd16[k]) : int'(wd8), 0);
        end
    endtask

    task automatic run_cell(input int ii, input int jj, input bit m,
                            input int d, input int u, input int l, input bit extra);
        int t, res, dr, ea;
        t = 0;
        while (!all_idle() && t < 50) begin tick(); t++; end
        nv[0] = 16'(d);
        nv[1] = 16'(u);
        nv[2] = 16'(l);
        clear_counts();
        i_in = 9'(ii);
        j_in = 9'(jj);
        match = m;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        i_in  = 9'($urandom_range(0, 127));
        j_in  = 9'($urandom_range(0, 127));
        match = ~m;
        if (extra) begin
            tick();
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        t = 0;
        while (!(all_written() && all_idle()) && t < 40) begin tick(); t++; end
        tick();
        tick();
        ea = ((jj + 1) + (N + 1) * (ii + 1)) & 32'h7FFF;
        for (int k = 0; k < 4; k++) begin
            model(SWS[k], d, u, l, m, res, dr);
            chk($sformatf("we_count%0d", k), we_cnt[k], 1);
            chk($sformatf("en_count%0d", k), en_cnt[k], 3);
            chk($sformatf("latency%0d", k), we_cyc[k], 5 + LATS[k]);
            chk($sformatf("addr%0d", k), got_addr[k], ea);
            chk($sformatf("data%0d", k), got_data[k], res);
            chk($sformatf("dir%0d", k), got_dir[k], dr);
            chk($sformatf("hold%0d", k), int'(wr_addr[k]), ea);
        end
    endtask

    initial begin
        int d, u, l;
        nv[0] = '0;
        nv[1] = '0;
        nv[2] = '0;
        clear_counts();
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        run_cell(0, 0, 1'b1, 0, -2, -2, 1'b0);
        run_cell(0, 0, 1'b0, -3, -2, -6, 1'b0);
        run_cell(5, 9, 1'b0, -10, 0, 0, 1'b0);
        run_cell(1, 1, 1'b1, 127, 0, 0, 1'b0);
        run_cell(7, 7, 1'b0, -128, -128, -128, 1'b0);
        run_cell(2, 3, 1'b1, 4, 9, -1, 1'b1);
        run_cell(127, 127, 1'b0, 3, 1, 2, 1'b0);
        run_cell(0, 127, 1'b1, 32767, -32768, 0, 1'b0);

        // Reset in the second REQ cycle: outputs clear at once and no write follows.
        nv[0] = 16'd5;
        clear_counts();
        i_in = 9'd4;
        j_in = 9'd4;
        match = 1'b1;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_zero("midrst");
        tick();
        tick();
        rst = 1'b0;
        clear_counts();
        for (int t = 0; t < 12; t++) tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_no_we%0d", k), we_cnt[k], 0);
            chk($sformatf("rst_no_en%0d", k), en_cnt[k], 0);
        end
        run_cell(0, 0, 1'b1, 0, -2, -2, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                d = int'($urandom_range(0, 400)) - 200;
                u = int'($urandom_range(0, 400)) - 200;
                l = int'($urandom_range(0, 400)) - 200;
            end else begin
                d = int'($urandom_range(0, 65535)) - 32768;
                u = int'($urandom_range(0, 65535)) - 32768;
                l = int'($urandom_range(0, 65535)) - 32768;
            end
            run_cell(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                     1'($urandom_range(0, 1)), d, u, l, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
